// File: rtl/rob_wb_arbiter_pkg.sv
// Shared types for the ROB writeback arbiter: exception codes, writeback payload, idle value.
package rob_wb_arbiter_pkg;

    localparam int RobDepth = 32;
    localparam int RobW     = $clog2(RobDepth);

    typedef enum logic [3:0] {
        EXP_NONE          = 4'd0,
        EXP_I_MISS_ALIGN  = 4'd1,
        EXP_I_ACC_FAULT   = 4'd2,
        EXP_ILL_INST      = 4'd3,
        EXP_BREAK         = 4'd4,
        EXP_LD_MISS_ALIGN = 4'd5
    } ExpCode_t;

    localparam int ExpW = $bits(ExpCode_t);

    typedef struct packed {
        logic [RobW-1:0] rob_id;
        logic            exp_;
        ExpCode_t        exp_code;
        logic            pred_miss_;
        logic            jump_miss_;
    } WbReq_t;

    // Idle bus value: ids/codes zero, active-low flags deasserted.
    localparam WbReq_t WB_IDLE = '{rob_id: '0, exp_: 1'b1, exp_code: EXP_NONE,
                                   pred_miss_: 1'b1, jump_miss_: 1'b1};

endpackage

// File: rtl/rob_wb_arbiter_rr.sv
// Generic round-robin picker: search starts just after last_grant; ACT is the asserted request level.
module rr_arbiter #(
    parameter int  REQ = 4,
    parameter bit  ACT = 1'b1,
    localparam int REQW = $clog2(REQ)
) (
    input  logic [REQ-1:0]  req,
    input  logic [REQW-1:0] last_grant,
    output logic [REQ-1:0]  grant,
    output logic [REQW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [REQW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 1; k <= REQ; k++) begin
            idx = REQW'((int'(last_grant) + k) % REQ);
            if (!grant_valid && (req[idx] == ACT)) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Shares the ROB status writeback port among REQ execution units via one-entry slots.
// Optional WB_EXP_PRIORITY_EN: exceptional/mispredict slots win over normal ones.
module rob_wb_arbiter
    import rob_wb_arbiter_pkg::*;
#(
    parameter int  REQ       = 4,
    parameter int  ROB_DEPTH = RobDepth,
    localparam int ROB       = $clog2(ROB_DEPTH),
    localparam int REQW      = $clog2(REQ)
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      flush_,
    input  logic [REQ-1:0]            req_e_,
    input  logic [REQ-1:0][ROB-1:0]   req_rob_id,
    input  logic [REQ-1:0]            req_exp_,
    input  logic [REQ-1:0][ExpW-1:0]  req_exp_code,
    input  logic [REQ-1:0]            req_pred_miss_,
    input  logic [REQ-1:0]            req_jump_miss_,
    output logic [REQ-1:0]            req_busy,
    output logic                      wb_e_,
    output logic [ROB-1:0]            wb_rob_id,
    output logic                      wb_exp_,
    output ExpCode_t                  wb_exp_code,
    output logic                      wb_pred_miss_,
    output logic                      wb_jump_miss_
);

    logic [REQ-1:0]  slot_valid;
    WbReq_t [REQ-1:0] slot;
    WbReq_t [REQ-1:0] req_pkt;
    logic [REQ-1:0]  arb_req;
    logic [REQ-1:0]  grant_raw;
    logic [REQ-1:0]  grant;
    logic [REQ-1:0]  capture;
    logic [REQW-1:0] last_grant;
    logic [REQW-1:0] grant_idx;
    logic            grant_any;
    logic            gv;
    WbReq_t          wb;

    for (genvar i = 0; i < REQ; i++) begin : g_req
        assign req_pkt[i] = '{rob_id: req_rob_id[i], exp_: req_exp_[i],
                              exp_code: ExpCode_t'(req_exp_code[i]),
                              pred_miss_: req_pred_miss_[i], jump_miss_: req_jump_miss_[i]};
        assign capture[i] = !req_e_[i] && !req_busy[i] && flush_;
    end

`ifdef WB_EXP_PRIORITY_EN
    logic [REQ-1:0] hp;
    always_comb begin
        hp = '0;
        for (int i = 0; i < REQ; i++)
            hp[i] = slot_valid[i] && (!slot[i].exp_ || !slot[i].pred_miss_ || !slot[i].jump_miss_);
        arb_req = (|hp) ? hp : slot_valid;
    end
`else
    assign arb_req = slot_valid;
`endif

    rr_arbiter #(.REQ(REQ), .ACT(1'b1)) u_rr (
        .req         (arb_req),
        .last_grant  (last_grant),
        .grant       (grant_raw),
        .grant_idx   (grant_idx),
        .grant_valid (grant_any)
    );

    // Flush kills the grant so nothing reaches the ROB in the flush cycle.
    assign grant    = grant_raw & {REQ{flush_}};
    assign gv       = grant_any && flush_;
    assign req_busy = slot_valid & ~grant;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            slot_valid <= '0;
            slot       <= '0;
            last_grant <= REQW'(REQ - 1);
        end else if (!flush_) begin
            slot_valid <= '0;
        end else begin
            if (gv) last_grant <= grant_idx;
            for (int i = 0; i < REQ; i++) begin
                if (capture[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot[i]       <= req_pkt[i];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign wb            = gv ? slot[grant_idx] : WB_IDLE;
    assign wb_e_         = !gv;
    assign wb_rob_id     = wb.rob_id;
    assign wb_exp_       = wb.exp_;
    assign wb_exp_code   = wb.exp_code;
    assign wb_pred_miss_ = wb.pred_miss_;
    assign wb_jump_miss_ = wb.jump_miss_;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Self-checking bench for rob_wb_arbiter: directed scenarios plus random traffic vs a slot/pointer model.
module tb_rob_wb_arbiter;
    import rob_wb_arbiter_pkg::*;

    localparam int REQ = 4;
    localparam int ROB = RobW;

    logic                     clk = 1'b0;
    logic                     reset_;
    logic                     flush_;
    logic [REQ-1:0]           req_e_;
    logic [REQ-1:0][ROB-1:0]  req_rob_id;
    logic [REQ-1:0]           req_exp_;
    logic [REQ-1:0][ExpW-1:0] req_exp_code;
    logic [REQ-1:0]           req_pred_miss_;
    logic [REQ-1:0]           req_jump_miss_;
    logic [REQ-1:0]           req_busy;
    logic                     wb_e_;
    logic [ROB-1:0]           wb_rob_id;
    logic                     wb_exp_;
    ExpCode_t                 wb_exp_code;
    logic                     wb_pred_miss_;
    logic                     wb_jump_miss_;

    rob_wb_arbiter #(.REQ(REQ)) dut (
        .clk(clk), .reset_(reset_), .flush_(flush_), .req_e_(req_e_),
        .req_rob_id(req_rob_id), .req_exp_(req_exp_), .req_exp_code(req_exp_code),
        .req_pred_miss_(req_pred_miss_), .req_jump_miss_(req_jump_miss_),
        .req_busy(req_busy), .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_exp_(wb_exp_),
        .wb_exp_code(wb_exp_code), .wb_pred_miss_(wb_pred_miss_), .wb_jump_miss_(wb_jump_miss_)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: pending flag + payload per requester, and the last requester granted.
    bit m_v[REQ];
    int m_id[REQ], m_exp[REQ], m_code[REQ], m_pm[REQ], m_jm[REQ];
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic idle_inputs();
        flush_ = 1'b1;
        req_e_ = '1;
        req_rob_id = '0;
        req_exp_ = '1;
        req_exp_code = '0;
        req_pred_miss_ = '1;
        req_jump_miss_ = '1;
    endtask

    task automatic set_req(input int i, input int id, input bit ex, input int code);
        req_e_[i] = 1'b0;
        req_rob_id[i] = ROB'(id);
        req_exp_[i] = ex;
        req_exp_code[i] = ExpW'(code);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        #1;
        chk("rst_wb_e", wb_e_, 1);
        chk("rst_id", wb_rob_id, 0);
        chk("rst_flags", {wb_exp_, wb_pred_miss_, wb_jump_miss_}, 3'b111);
        chk("rst_code", wb_exp_code, 0);
        chk("rst_busy", req_busy, 0);
        @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        for (int i = 0; i < REQ; i++) m_v[i] = 1'b0;
        m_ptr = REQ - 1;
    endtask

    // Check outputs against the model for the current inputs, then advance one clock.
    task automatic cyc();
        int win;
        bit cand[REQ];
        bit busy[REQ];
        bit any_hp;
        #1;
        win = -1;
        any_hp = 1'b0;
        for (int i = 0; i < REQ; i++) begin
            cand[i] = m_v[i];
`ifdef WB_EXP_PRIORITY_EN
            if (m_v[i] && (m_exp[i] == 0 || m_pm[i] == 0 || m_jm[i] == 0)) any_hp = 1'b1;
`endif
        end
        if (any_hp)
            for (int i = 0; i < REQ; i++)
                cand[i] = m_v[i] && (m_exp[i] == 0 || m_pm[i] == 0 || m_jm[i] == 0);
        if (flush_)
            for (int k = 1; k <= REQ; k++)
                if (win < 0 && cand[(m_ptr + k) % REQ]) win = (m_ptr + k) % REQ;
        chk("wb_e", wb_e_, (win < 0) ? 1 : 0);
        chk("wb_id", wb_rob_id, (win < 0) ? 0 : m_id[win]);
        chk("wb_exp", wb_exp_, (win < 0) ? 1 : m_exp[win]);
        chk("wb_code", wb_exp_code, (win < 0) ? 0 : m_code[win]);
        chk("wb_pm", wb_pred_miss_, (win < 0) ? 1 : m_pm[win]);
        chk("wb_jm", wb_jump_miss_, (win < 0) ? 1 : m_jm[win]);
        for (int i = 0; i < REQ; i++) begin
            busy[i] = m_v[i] && (i != win);
            chk("busy", req_busy[i], busy[i]);
        end
        @(posedge clk);
        if (!flush_) begin
            for (int i = 0; i < REQ; i++) m_v[i] = 1'b0;
        end else begin
            if (win >= 0) begin
                m_ptr = win;
                m_v[win] = 1'b0;
            end
            for (int i = 0; i < REQ; i++)
                if (!req_e_[i] && !busy[i]) begin
                    m_v[i] = 1'b1;
                    m_id[i] = int'(req_rob_id[i]);
                    m_exp[i] = int'(req_exp_[i]);
                    m_code[i] = int'(req_exp_code[i]);
                    m_pm[i] = int'(req_pred_miss_[i]);
                    m_jm[i] = int'(req_jump_miss_[i]);
                end
        end
        @(negedge clk);
    endtask

    initial begin
        int prev;
        reset_ = 1'b1;
        idle_inputs();

        // Single request
        do_reset();
        set_req(2, 5, 1'b1, 0);
        cyc();
        idle_inputs();
        #1;
        chk("single_e", wb_e_, 0);
        chk("single_id", wb_rob_id, 5);
        chk("single_busy", req_busy, 0);
        cyc();
        chk("single_after_e", wb_e_, 1);
        chk("single_after_id", wb_rob_id, 0);
        cyc();

        // Full contention
        do_reset();
        for (int i = 0; i < REQ; i++) set_req(i, i + 1, 1'b1, 0);
        cyc();
        idle_inputs();
        for (int k = 0; k < REQ; k++) begin
            #1;
            chk("cont_id", wb_rob_id, k + 1);
            if (k < 3) chk("cont_busy3", req_busy[3], 1);
            cyc();
        end
        chk("cont_done", wb_e_, 1);

        // Reload on grant
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_req(0, 7 + k, 1'b1, 0);
            #1;
            chk("reload_busy0", req_busy[0], 0);
            if (k > 0) chk("reload_id", wb_rob_id, 6 + k);
            cyc();
        end
        idle_inputs();
        #1;
        chk("reload_id", wb_rob_id, 9);
        cyc();

        // Fairness between two persistent requesters
        do_reset();
        set_req(0, 10, 1'b1, 0);
        set_req(1, 11, 1'b1, 0);
        cyc();
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_e", wb_e_, 0);
            if (k == 0) chk("fair_first", wb_rob_id, 10);
            else chk("fair_alt", (int'(wb_rob_id) != prev), 1);
            prev = int'(wb_rob_id);
            cyc();
        end
        idle_inputs();
        cyc();

        // Flush drops pending slots and same-cycle requests
        do_reset();
        set_req(1, 3, 1'b1, 0);
        set_req(3, 4, 1'b1, 0);
        cyc();
        idle_inputs();
        flush_ = 1'b0;
        set_req(0, 6, 1'b1, 0);
        #1;
        chk("flush_e", wb_e_, 1);
        cyc();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_flush_e", wb_e_, 1);
            chk("post_flush_busy", req_busy, 0);
            cyc();
        end

        // Exception priority: pointer at 0, slots 1 and 2 pending
        do_reset();
        set_req(0, 1, 1'b1, 0);
        cyc();
        idle_inputs();
        set_req(1, 12, 1'b1, 0);
        set_req(2, 13, 1'b0, EXP_I_MISS_ALIGN);
        cyc();
        idle_inputs();
        #1;
`ifdef WB_EXP_PRIORITY_EN
        chk("prio_first", wb_rob_id, 13);
        chk("prio_code", wb_exp_code, EXP_I_MISS_ALIGN);
`else
        chk("prio_first", wb_rob_id, 12);
`endif
        cyc();
        #1;
`ifdef WB_EXP_PRIORITY_EN
        chk("prio_second", wb_rob_id, 12);
`else
        chk("prio_second", wb_rob_id, 13);
`endif
        cyc();

        // Random traffic
        do_reset();
        for (int n = 0; n < 600; n++) begin
            flush_ = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < REQ; i++) begin
                req_e_[i] = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
                req_rob_id[i] = ROB'($urandom);
                req_exp_[i] = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                req_exp_code[i] = ExpW'($urandom_range(0, 5));
                req_pred_miss_[i] = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
                req_jump_miss_[i] = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            end
            cyc();
        end
        idle_inputs();
        for (int k = 0; k < REQ + 1; k++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rob_wb_arbiter.md
Name: rob_wb_arbiter

Overview:
- Shares the single ROB status writeback port (wb_e_, wb_rob_id, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_) among REQ execution units (ALU, branch, mul/div, LSU).
- Each requester owns a one-entry holding slot; a round-robin arbiter issues one slot per cycle to the ROB.
- Sits between the execution-unit writeback outputs and rob_status.

Parameters:
- REQ, 4, number of writeback requesters (>=2).
- ROB_DEPTH, `RobDepth, ROB entries.
- ROB, $clog2(ROB_DEPTH), ROB id width (constant, not overridden).
- REQW, $clog2(REQ), requester index width (constant).

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous, active-low reset.
- flush_  in  1  active-low pipeline flush from rob_status.
- req_e_  in  REQ  active-low writeback request, one bit per requester.
- req_rob_id  in  REQ x ROB  ROB id per requester.
- req_exp_  in  REQ  active-low exception flag.
- req_exp_code  in  REQ x $bits(ExpCode_t)  exception code.
- req_pred_miss_  in  REQ  active-low branch mispredict.
- req_jump_miss_  in  REQ  active-low jump target miss.
- req_busy  out  REQ  active-high; the slot cannot accept a request this cycle.
- wb_e_  out  1  active-low ROB writeback enable.
- wb_rob_id  out  ROB  granted ROB id.
- wb_exp_  out  1  granted exception flag.
- wb_exp_code  out  $bits(ExpCode_t)  granted exception code.
- wb_pred_miss_  out  1  granted mispredict flag.
- wb_jump_miss_  out  1  granted jump miss flag.

Behaviour:
- Slot state: slot_valid[REQ] plus a WbReq_t payload per requester.
- Reset: slot_valid all 0. Round-robin pointer last_grant = REQ-1, so requester 0 has first priority.
- Outputs during and after reset: wb_e_ = 1, all other wb_* = 0, active-low flags = 1, req_busy = 0.

Capture and backpressure:
- Requester i's request is captured at posedge when req_e_[i] == 0, req_busy[i] == 0 and flush_ == 1.
- req_busy[i] = slot_valid[i] && !grant[i] (combinational).
- A slot granted this cycle may be reloaded by a new request in the same cycle, giving back-to-back throughput of 1/cycle per requester when uncontended.
- A request issued while req_busy[i] == 1 is ignored; the requester must hold it.

Arbitration and output:
- Combinational, among valid slots only.
- Search order is last_grant+1, last_grant+2, ... modulo REQ; the first valid slot wins.
- last_grant updates to the winner at posedge only when a grant occurs.
- Latency: a request captured at edge N appears on wb_* during cycle N (after that edge) at the earliest. This is 1 cycle request-to-writeback; there is no same-cycle bypass.
- wb_e_ = 0 iff any slot is valid and flush_ == 1. wb_* are driven from the granted slot.
- When wb_e_ == 1, all wb_* are forced to idle values (id/code 0, active-low flags 1).
- Starvation bound: any valid slot is granted within REQ cycles.

Flush:
- When flush_ == 0, wb_e_ is forced to 1 and grant to 0.
- All slots clear at posedge; requests presented in the flush cycle are dropped.
- last_grant is unchanged.
- req_busy is 0 in the cycle following a flush.

Reset mid-operation:
- Asynchronous assertion immediately clears slots, pointer and outputs.
- Deassertion is synchronised externally.

Optional Feature:
- Macro: WB_EXP_PRIORITY_EN.
- Defined: valid slots with exp_ == 0 or pred_miss_ == 0 or jump_miss_ == 0 form a high-priority class.
  - If the class is non-empty, round-robin runs over that class only, using the same pointer.
  - Otherwise round-robin runs over all valid slots.
  - The starvation bound becomes REQ cycles per class; normal requests can stall while exceptional ones persist.
- Undefined: pure round-robin as above; priority logic absent.

Decomposition:
- rob.svh (shared header) holds:
  - WbReq_t packed struct {rob_id[ROB], exp_, exp_code, pred_miss_, jump_miss_}.
  - The idle WbReq_t constant.
- exception.svh supplies ExpCode_t.
- One sub-module, rr_arbiter:
  - Parameters REQ, ACT.
  - Inputs req vector and last_grant; outputs one-hot grant, grant index and valid.
  - Reusable by the issue/ALU-port schedulers.

Test Plan:
- Single request: reset, then req_e_[2] = 0, rob_id = 5 for one cycle -> next cycle wb_e_ = 0, wb_rob_id = 5, req_busy all 0; following cycle wb_e_ = 1, wb_rob_id = 0.
- Full contention: all 4 requesters request ids 1, 2, 3, 4 in the same cycle -> grants appear in consecutive cycles in order 0, 1, 2, 3 (ids 1, 2, 3, 4). req_busy[3] stays 1 for 3 cycles after capture.
- Reload on grant: requester 0 holds req_e_ = 0 with ids 7, 8, 9 on successive cycles, no contention -> wb_rob_id 7, 8, 9 on consecutive cycles, and req_busy[0] is never 1.
- Fairness: requesters 0 and 1 request continuously -> grants alternate 0, 1, 0, 1 with no two consecutive grants to one requester.
- Flush: slots 1 and 3 valid, flush_ = 0 for one cycle -> wb_e_ = 1 that cycle; next cycle slot_valid all 0 and wb_e_ = 1. A request made during the flush cycle never appears on wb_*.
- WB_EXP_PRIORITY_EN: last_grant = 0, slots 1 and 2 valid, slot 2 has exp_ = 0 with exp_code = EXP_I_MISS_ALIGN -> slot 2 granted first, slot 1 next cycle. With the macro undefined -> slot 1 first.
